mem_store_unit: RTL and testbench

//   Store-side partner of the write-back load path: accepts one store from the MEM stage,

---
 rtl/mem_store_unit.sv | 132 +++++++++++++
 tb/tb_mem_store_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// Store unit: lane-aligns one MEM-stage store into a 64-bit strobed write request and
// holds the pipeline until the write is accepted, rejected as misaligned, or times out.
module mem_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic [2:0]  mem,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  output logic        mem_w_valid,
  input  logic        mem_w_ready,
  output logic [63:0] mem_w_addr,
  output logic [63:0] mem_w_data,
  output logic [7:0]  mem_w_mask,
  output logic        stall,
  output logic        store_done,
  output logic        store_misalign,
  output logic        store_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  // Unshifted byte strobes for a size code; the sign bit of the code is irrelevant to stores.
  function automatic logic [7:0] size_mask(input logic [2:0] code);
    logic [7:0] m;
    case (code)
      3'b001, 3'b100: m = 8'h01;
      3'b010, 3'b101: m = 8'h03;
      3'b011, 3'b110: m = 8'h0F;
      3'b111:         m = 8'hFF;
      default:        m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input logic [2:0] code, input logic [2:0] off);
    logic ok;
    case (code)
      3'b001, 3'b100: ok = 1'b1;
      3'b010, 3'b101: ok = (off[0] == 1'b0);
      3'b011, 3'b110: ok = (off[1:0] == 2'b00);
      3'b111:         ok = (off == 3'b000);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              valid_r, done_r, timeout_r, misalign_r;
  logic [63:0]       addr_r, data_r;
  logic [7:0]        mask_r;
  logic [2:0]        off_s;
  logic              active_s, aligned_s, accept_s, misalign_s, cnt_last_s, stall_s;

  assign off_s      = st_addr[2:0];
  assign active_s   = st_req & (mem != 3'b000);
  assign aligned_s  = is_aligned(mem, off_s);
  assign accept_s   = (state_r == ST_IDLE) & active_s & aligned_s;
  assign misalign_s = (state_r == ST_IDLE) & active_s & ~aligned_s;
  assign cnt_last_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and pipeline-hold decode.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = accept_s;
        if (accept_s) state_next_s = ST_REQ;
        else          state_next_s = ST_IDLE;
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (mem_w_ready)     state_next_s = ST_DONE;
        else if (cnt_last_s) state_next_s = ST_ABORT;
        else                 state_next_s = ST_REQ;
      end
      ST_DONE:  state_next_s = ST_IDLE;
      ST_ABORT: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, registered status outputs, captured request and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      misalign_r <= 1'b0;
      cnt_r      <= '0;
      addr_r     <= 64'h0;
      data_r     <= 64'h0;
      mask_r     <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      valid_r    <= (state_next_s == ST_REQ);
      done_r     <= (state_next_s == ST_DONE);
      timeout_r  <= (state_next_s == ST_ABORT);
      misalign_r <= misalign_s;
      if (accept_s) begin
        addr_r <= {st_addr[63:3], 3'b000};
        data_r <= st_data << {off_s, 3'b000};
        mask_r <= size_mask(mem) << off_s;
        cnt_r  <= '0;
      end else if ((state_r == ST_REQ) && !mem_w_ready) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Reset forces the hold low even while a request is presented in IDLE.
  assign stall          = stall_s & ~rst;
  assign mem_w_valid    = valid_r;
  assign mem_w_addr     = addr_r;
  assign mem_w_data     = data_r;
  assign mem_w_mask     = mask_r;
  assign store_done     = done_r;
  assign store_timeout  = timeout_r;
  assign store_misalign = misalign_r;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed self-checking bench for mem_store_unit (TIMEOUT_CYCLES=4).
module tb_mem_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [2:0]  mem;
  logic [63:0] st_addr, st_data;
  logic        mem_w_valid, mem_w_ready;
  logic [63:0] mem_w_addr, mem_w_data;
  logic [7:0]  mem_w_mask;
  logic        stall, store_done, store_misalign, store_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .st_req(st_req), .mem(mem), .st_addr(st_addr), .st_data(st_data),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask), .stall(stall), .store_done(store_done),
    .store_misalign(store_misalign), .store_timeout(store_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d);
    st_req = req; mem = sz; st_addr = a; st_data = d;
  endtask

  int hs, d1, d2;
  logic [63:0] data2;

  initial begin
    rst = 1'b1; mem_w_ready = 1'b0;
    drive(1'b0, 3'b000, 64'h0, 64'h0);
    @(negedge clk);
    check_val("rst_valid", {63'h0, mem_w_valid}, 64'h0);
    check_val("rst_outs", {stall, store_done, store_misalign, store_timeout}, 64'h0);
    check_val("rst_addr", mem_w_addr, 64'h0);
    check_val("rst_mask", {56'h0, mem_w_mask}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // SB, ready on first REQ cycle
    drive(1'b1, 3'b001, 64'h1003, 64'hAB);
    #1 check_val("sb_stall_idle", {63'h0, stall}, 64'h1);
    @(negedge clk);
    check_val("sb_valid", {63'h0, mem_w_valid}, 64'h1);
    check_val("sb_addr", mem_w_addr, 64'h1000);
    check_val("sb_data", mem_w_data, 64'hAB000000);
    check_val("sb_mask", {56'h0, mem_w_mask}, 64'h08);
    mem_w_ready = 1'b1;
    @(negedge clk);
    check_val("sb_done", {62'h0, store_done, mem_w_valid}, 64'h2);
    check_val("sb_stall_done", {63'h0, stall}, 64'h0);
    drive(1'b0, 3'b000, 64'h0, 64'h0); mem_w_ready = 1'b0;
    @(negedge clk);
    check_val("sb_done_once", {63'h0, store_done}, 64'h0);

    // SD, ready after three wait cycles
    drive(1'b1, 3'b111, 64'h2000, 64'h1122334455667788);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("sd_valid%0d", i), {62'h0, mem_w_valid, store_done}, 64'h2);
      mem_w_ready = (i == 3);
    end
    check_val("sd_data", mem_w_data, 64'h1122334455667788);
    check_val("sd_mask", {56'h0, mem_w_mask}, 64'hFF);
    @(negedge clk);
    check_val("sd_done", {62'h0, store_done, mem_w_valid}, 64'h2);
    drive(1'b0, 3'b000, 64'h0, 64'h0); mem_w_ready = 1'b0;
    @(negedge clk);

    // SW misaligned
    drive(1'b1, 3'b011, 64'h3002, 64'hDEADBEEF);
    #1 check_val("sw_stall", {63'h0, stall}, 64'h0);
    @(negedge clk);
    check_val("sw_misalign", {61'h0, store_misalign, mem_w_valid, store_done}, 64'h4);
    drive(1'b0, 3'b000, 64'h0, 64'h0);
    @(negedge clk);
    check_val("sw_misalign_once", {62'h0, store_misalign, mem_w_valid}, 64'h0);

    // SH with ready stuck low -> timeout after 4 valid cycles
    drive(1'b1, 3'b010, 64'h4006, 64'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("sh_valid%0d", i), {62'h0, mem_w_valid, store_timeout}, 64'h2);
    end
    check_val("sh_data", mem_w_data, 64'hBEEF000000000000);
    check_val("sh_mask", {56'h0, mem_w_mask}, 64'hC0);
    @(negedge clk);
    check_val("sh_timeout", {60'h0, store_timeout, mem_w_valid, stall, store_done}, 64'h8);
    drive(1'b0, 3'b000, 64'h0, 64'h0);
    @(negedge clk);
    check_val("sh_timeout_once", {63'h0, store_timeout}, 64'h0);

    // Reset in the middle of REQ
    drive(1'b1, 3'b001, 64'h10, 64'h77);
    @(negedge clk);
    check_val("rr_valid", {63'h0, mem_w_valid}, 64'h1);
    #2 rst = 1'b1;
    #1 check_val("rr_async", {62'h0, mem_w_valid, stall}, 64'h0);
    @(negedge clk);
    rst = 1'b0; drive(1'b0, 3'b000, 64'h0, 64'h0); mem_w_ready = 1'b1;
    @(negedge clk);
    check_val("rr_no_pulse", {61'h0, store_done, store_timeout, mem_w_valid}, 64'h0);
    mem_w_ready = 1'b0;

    // st_req with mem=000 does nothing
    drive(1'b1, 3'b000, 64'h3, 64'h55);
    #1 check_val("none_stall", {63'h0, stall}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check_val("none_quiet", {61'h0, mem_w_valid, store_misalign, store_done}, 64'h0);
    drive(1'b0, 3'b000, 64'h0, 64'h0);
    @(negedge clk);

    // Back-to-back SB then SH with ready held high
    hs = 0; d1 = -1; d2 = -1; data2 = 64'h0;
    mem_w_ready = 1'b1;
    drive(1'b1, 3'b001, 64'h1001, 64'h5A);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_w_valid && mem_w_ready) begin
        hs++;
        if (hs == 2) data2 = mem_w_data;
      end
      if (store_done) begin
        if (d1 < 0) begin
          d1 = c;
          drive(1'b1, 3'b010, 64'h5002, 64'h1234);
        end else begin
          d2 = c;
          drive(1'b0, 3'b000, 64'h0, 64'h0);
        end
      end
    end
    mem_w_ready = 1'b0;
    check_val("b2b_handshakes", 64'(hs), 64'd2);
    check_val("b2b_done_gap", 64'(d2 - d1), 64'd3);
    check_val("b2b_data2", data2, 64'h12340000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
